bitwise_slice_unit: RTL and testbench

- Parametrised, multi-cycle bitwise logic engine. Successor to the fixed 32-bit combinational AND: generalised in width and operation, with a start/done handshake.
- Operands are latched on start. The result is computed SLICE bits per cycle, LSB slice first, into a result register.
- Sits beside the ALU as a reusable logic-op datapath element and as a reference block for handshake-driven units.

---
 rtl/bitwise_slice_unit_if.sv | 30 +++
 rtl/bitwise_slice_unit.sv | 130 +++++++++++++
 tb/tb_bitwise_slice_unit.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_slice_unit_if.sv
// Handshake and data bundle for bitwise_slice_unit.
// Latency: none (wires only).
// Backpressure: none; start is simply ignored while the engine is busy.
//
// Signals:
//   start, op, A, B  request side, driven by the master
//   busy, done       status, driven by the engine
//   res, zero        registered result and its all-zero flag
interface bitwise_slice_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             zero;

  modport master (
    output start, op, A, B,
    input  busy, done, res, zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, res, zero
  );
endinterface

// File: rtl/bitwise_slice_unit.sv
// Multi-cycle bitwise AND/OR/XOR/NOR engine, SLICE result bits per cycle, LSB slice first.
// Latency: WIDTH/SLICE cycles from accepting start to the one-cycle done pulse.
// Backpressure: start is accepted only in IDLE or DONE; start during BUSY is dropped, not queued.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, wins over start
//   bus  slave side of bitwise_slice_unit_if (start/op/A/B in, busy/done/res/zero out)
module bitwise_slice_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bitwise_slice_unit_if.slave  bus
);

  localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (SLICE == 0) begin : g_bad_slice
      $error("bitwise_slice_unit: SLICE must be non-zero");
    end else if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("bitwise_slice_unit: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [1:0]       opl;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic [WIDTH-1:0] res_next;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sf;

  assign accept = bus.start && ((state == IDLE) || (state == DONE));

  // Only the slice selected by the counter changes; the loop keeps every
  // part-select index constant so the mux is a plain per-slice enable.
  always_comb begin
    res_next = res_q;
    sa       = '0;
    sb       = '0;
    sf       = '0;
    for (int s = 0; s < N; s++) begin
      if (cnt == CW'(s)) begin
        sa = opa[s*SLICE +: SLICE];
        sb = opb[s*SLICE +: SLICE];
        case (opl)
          2'b00:   sf = sa & sb;
          2'b01:   sf = sa | sb;
          2'b10:   sf = sa ^ sb;
          default: sf = ~(sa | sb);
        endcase
        res_next[s*SLICE +: SLICE] = sf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      opa    <= '0;
      opb    <= '0;
      opl    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state  <= BUSY;
            busy_q <= 1'b1;
            opa    <= bus.A;
            opb    <= bus.B;
            opl    <= bus.op;
            cnt    <= '0;
            res_q  <= '0;
            // zero keeps reporting the previous result until this one completes
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          res_q <= res_next;
          if (cnt == LAST) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            // flag taken from the full value including the slice written now
            zero_q <= (res_next == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_bitwise_slice_unit.sv
module tb_bitwise_slice_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bitwise_slice_unit_if #(.WIDTH(32)) bus ();
  bitwise_slice_unit_if #(.WIDTH(16)) bus16 ();

  bitwise_slice_unit #(.WIDTH(32), .SLICE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bitwise_slice_unit #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-word bitwise result, independent of slicing.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Issue one request on the 32-bit unit; scramble inputs while it runs.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic zfirst,
                       output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.op = 2'($urandom);
    lat = -1; bcnt = 0; zfirst = 1'bx;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) zfirst = bus.zero;
      if (bus.busy) bcnt++;
      if (bus.done) begin lat = j; break; end
    end
    r = bus.res;
    z = bus.zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0;
    bus16.start = 1'b0; bus16.op = 2'b00; bus16.A = '0; bus16.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.zero, bus.res} !== 35'd0) begin
      failures++;
      $display("FAIL reset32 got busy=%b done=%b zero=%b res=%h exp all 0", bus.busy, bus.done, bus.zero, bus.res);
    end
    checks++;
    if ({bus16.busy, bus16.done, bus16.zero, bus16.res} !== 19'd0) begin
      failures++;
      $display("FAIL reset16 got busy=%b done=%b zero=%b res=%h exp all 0", bus16.busy, bus16.done, bus16.zero, bus16.res);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got %b exp 0", bus.busy);
    end
  endtask

  task automatic test_ops();
    logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] exps[4] = '{32'h000000FF, 32'h00FFFFFF, 32'h00FFFF00, 32'hFF000000};
    logic [31:0] r, e;
    logic z, zf;
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], 32'h0000FFFF, 32'h00FF00FF, r, z, zf, lat, bc);
      e = model(ops[i], 32'h0000FFFF, 32'h00FF00FF);
      checks++;
      if (r !== exps[i] || r !== e) begin
        failures++;
        $display("FAIL op%0d_res got %h exp %h", i, r, exps[i]);
      end
      checks++;
      if (z !== 1'b0) begin
        failures++;
        $display("FAIL op%0d_zero got %b exp 0", i, z);
      end
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL op%0d_latency got %0d exp 4", i, lat);
      end
      checks++;
      if (bc !== 4) begin
        failures++;
        $display("FAIL op%0d_busy_cycles got %0d exp 4", i, bc);
      end
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.res !== exps[0]) begin
          failures++;
          $display("FAIL done_pulse got done=%b res=%h exp done=0 res=%h", bus.done, bus.res, exps[0]);
        end
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] r;
    logic z, zf;
    int lat, bc;
    do_op(2'b00, 32'hFFFF0000, 32'h0000FFFF, r, z, zf, lat, bc);
    checks++;
    if (r !== 32'h0 || z !== 1'b1) begin
      failures++;
      $display("FAIL zero_and got res=%h zero=%b exp res=00000000 zero=1", r, z);
    end
    do_op(2'b01, 32'hFFFF0000, 32'h0000FFFF, r, z, zf, lat, bc);
    checks++;
    if (zf !== 1'b1) begin
      failures++;
      $display("FAIL zero_hold got %b exp 1", zf);
    end
    checks++;
    if (r !== 32'hFFFFFFFF || z !== 1'b0) begin
      failures++;
      $display("FAIL zero_or got res=%h zero=%b exp res=ffffffff zero=0", r, z);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'h0000FFFF; bus.B = 32'h00FF00FF;
    @(posedge clk);
    #1;
    // start stays high with junk operands the whole BUSY period
    bus.A = $urandom; bus.B = $urandom; bus.op = 2'($urandom);
    lat = -1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.done) begin lat = j; break; end
      bus.A = $urandom; bus.B = $urandom;
    end
    checks++;
    if (lat !== 4 || bus.res !== 32'h000000FF) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d res=%h exp lat=4 res=000000ff", lat, bus.res);
    end
    bus.A = 32'hF0F0F0F0; bus.B = 32'hFFFFFFFF; bus.op = 2'b10;
    @(posedge clk);
    #1;
    bus.A = $urandom; bus.B = $urandom; bus.op = 2'($urandom);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", bus.busy, bus.done);
    end
    lat = -1;
    for (int j = 1; j < 20; j++) begin
      @(negedge clk);
      if (bus.done) begin lat = j; break; end
    end
    bus.start = 1'b0;
    checks++;
    if (lat !== 4 || bus.res !== 32'h0F0F0F0F || bus.zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d res=%h zero=%b exp lat=4 res=0f0f0f0f zero=0", lat, bus.res, bus.zero);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] r, a, b;
    logic [1:0] o;
    logic z, zf;
    int lat, bc;
    do_op(2'b00, 32'hFFFF0000, 32'h0000FFFF, r, z, zf, lat, bc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.A = 32'hFFFFFFFF; bus.B = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.res !== 32'h000000FF) begin
      failures++;
      $display("FAIL midrst_pre got busy=%b res=%h exp busy=1 res=000000ff", bus.busy, bus.res);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.zero, bus.res} !== 35'd0) begin
      failures++;
      $display("FAIL midrst_post got busy=%b done=%b zero=%b res=%h exp all 0", bus.busy, bus.done, bus.zero, bus.res);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle got busy=%b done=%b exp 0 0", bus.busy, bus.done);
    end
    a = $urandom; b = $urandom; o = 2'($urandom);
    do_op(o, a, b, r, z, zf, lat, bc);
    checks++;
    if (r !== model(o, a, b) || lat !== 4) begin
      failures++;
      $display("FAIL midrst_fresh got res=%h lat=%0d exp res=%h lat=4", r, lat, model(o, a, b));
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, b, e;
    logic [1:0] o;
    logic z, zf;
    int lat, bc;
    for (int i = 0; i < 25; i++) begin
      a = $urandom; b = $urandom; o = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        b = ~a;
        o = (i % 2 == 0) ? 2'b00 : 2'b10;
      end
      e = model(o, a, b);
      do_op(o, a, b, r, z, zf, lat, bc);
      checks++;
      if (r !== e || z !== (e == 32'h0) || lat !== 4 || bc !== 4) begin
        failures++;
        $display("FAIL rand%0d got res=%h zero=%b lat=%0d busy=%0d exp res=%h zero=%b lat=4 busy=4",
                 i, r, z, lat, bc, e, (e == 32'h0));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_slice16();
    logic [15:0] a, b, e;
    logic [1:0] o;
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        a = 16'h00FF; b = 16'h0F0F; o = 2'b10;
      end else begin
        a = 16'($urandom); b = 16'($urandom); o = 2'($urandom);
      end
      e = 16'(model(o, {16'h0, a}, {16'h0, b}));
      @(negedge clk);
      bus16.start = 1'b1; bus16.op = o; bus16.A = a; bus16.B = b;
      @(posedge clk);
      #1;
      bus16.start = 1'b0; bus16.A = 16'($urandom); bus16.B = 16'($urandom);
      lat = -1; bc = 0;
      for (int j = 0; j < 20; j++) begin
        @(negedge clk);
        if (bus16.busy) bc++;
        if (bus16.done) begin lat = j; break; end
      end
      checks++;
      if (bus16.res !== e || lat !== 1 || bc !== 1 || bus16.zero !== (e == 16'h0)) begin
        failures++;
        $display("FAIL s16_%0d got res=%h lat=%0d busy=%0d zero=%b exp res=%h lat=1 busy=1 zero=%b",
                 i, bus16.res, lat, bc, bus16.zero, e, (e == 16'h0));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_ops();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_slice16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
